// File: rtl/rs_syndrome_accum.sv
// rtl/rs_syndrome_accum.sv - serial GF(2^8) S0/S1 syndrome accumulator for the Unity ECC decoder
// Optional framing check enabled by defining SYND_LAST_CHECK_EN.
module rs_syndrome_accum #(
    parameter int N_SYM = 80,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       s0,
    output logic [7:0]       s1,
    output logic             no_err,
    output logic [CNT_W-1:0] sym_cnt
`ifdef SYND_LAST_CHECK_EN
    ,
    input  logic             in_last,
    output logic             frame_err
`endif
);

    typedef enum logic {ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SYM - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] acc0;
    logic [7:0] acc1;
    logic       accept;
    logic       last_sym;
    logic       result_taken;

    // Multiply by alpha modulo x^8+x^6+x^4+x^3+x^2+x+1.
    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        mul_alpha = {x[6:0], 1'b0} ^ (x[7] ? 8'h5F : 8'h00);
    endfunction

    assign accept       = in_valid && in_ready;
    assign last_sym     = (sym_cnt == LAST_CNT);
    assign result_taken = out_valid && out_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last_sym) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
        if (clear) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Horner form: symbols arrive highest index first, so acc1 = acc1*alpha ^ c.
    always_ff @(posedge clk) begin
        if (rst || clear || result_taken) begin
            acc0    <= 8'h00;
            acc1    <= 8'h00;
            sym_cnt <= '0;
        end else if (accept) begin
            acc0    <= acc0 ^ in_sym;
            acc1    <= mul_alpha(acc1) ^ in_sym;
            sym_cnt <= sym_cnt + 1'b1;
        end
    end

`ifdef SYND_LAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || clear || result_taken) begin
            frame_err <= 1'b0;
        end else if (accept && (in_last != last_sym)) begin
            frame_err <= 1'b1;
        end
    end
`endif

    assign s0     = acc0;
    assign s1     = acc1;
    assign no_err = (acc0 == 8'h00) && (acc1 == 8'h00);

endmodule

// File: tb/tb_rs_syndrome_accum.sv
// tb/tb_rs_syndrome_accum.sv - directed/random bench for rs_syndrome_accum against a GF(2^8) sum model
module tb_rs_syndrome_accum;

    localparam int N = 80;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_sym = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    s0;
    logic [7:0]    s1;
    logic          no_err;
    logic [CW-1:0] sym_cnt;
`ifdef SYND_LAST_CHECK_EN
    logic          in_last = 1'b0;
    logic          frame_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] cw [0:N-1];
    logic [7:0] exp_s0;
    logic [7:0] exp_s1;

    always #5 clk = ~clk;

    rs_syndrome_accum #(.N_SYM(N), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sym(in_sym),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s0(s0),
        .s1(s1),
        .no_err(no_err),
        .sym_cnt(sym_cnt)
`ifdef SYND_LAST_CHECK_EN
        ,
        .in_last(in_last),
        .frame_err(frame_err)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h5F) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < e; k++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    task automatic model();
        exp_s0 = 8'h00;
        exp_s1 = 8'h00;
        for (int i = 0; i < N; i++) begin
            exp_s0 = exp_s0 ^ cw[i];
            exp_s1 = exp_s1 ^ gf_mul(cw[i], alpha_pow(i));
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) cw[i] = (mode == 0) ? 8'h00 : 8'($urandom);
    endtask

    // Symbol at position p (1-based, in arrival order) carries index N-p.
    task automatic send_cw(input int n_send, input bit bubbles, input int last_pos);
        for (int p = 1; p <= n_send; p++) begin
            for (int b = 0; b < 3 && bubbles && $urandom_range(0, 2) == 0; b++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_sym   = cw[N-p];
`ifdef SYND_LAST_CHECK_EN
            in_last  = (p == last_pos);
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
`ifdef SYND_LAST_CHECK_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic check_result(input string tag, input logic exp_fe);
        model();
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".s0"}, s0, exp_s0);
        chk({tag, ".s1"}, s1, exp_s1);
        chk({tag, ".no_err"}, no_err, (exp_s0 == 0) && (exp_s1 == 0));
        chk({tag, ".sym_cnt"}, sym_cnt, N);
`ifdef SYND_LAST_CHECK_EN
        chk({tag, ".frame_err"}, frame_err, exp_fe);
`else
        if (exp_fe) chk({tag, ".fe_unused"}, 0, 1);
`endif
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".in_ready"}, in_ready, 1);
        chk({tag, ".sym_cnt"}, sym_cnt, 0);
        chk({tag, ".s0"}, s0, 0);
        chk({tag, ".s1"}, s1, 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_idle(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");
        chk("reset.no_err", no_err, 1);

        // All-zero codeword; in_ready must be low for exactly one cycle.
        fill(0);
        send_cw(N, 1'b0, N);
        check_result("zero", 1'b0);
        @(posedge clk); #1;
        chk("zero.ready_back", in_ready, 1);
        chk("zero.ov_drop", out_valid, 0);

        fill(0);
        cw[8] = 8'h01;
        send_cw(N, 1'b0, N);
        check_result("err_idx8", 1'b0);
        chk("err_idx8.s1_const", s1, 8'h5F);
        handshake("err_idx8.hs");

        fill(0);
        cw[0] = 8'h03;
        send_cw(N, 1'b0, N);
        check_result("err_idx0", 1'b0);
        chk("err_idx0.s1_const", s1, 8'h03);
        handshake("err_idx0.hs");
        fill(0);
        cw[1] = 8'h01;
        send_cw(N, 1'b0, N);
        check_result("err_idx1", 1'b0);
        chk("err_idx1.s1_const", s1, 8'h02);
        handshake("err_idx1.hs");

        // Backpressure: result held, input ignored.
        fill(1);
        out_ready = 1'b0;
        send_cw(N, 1'b1, N);
        check_result("bp", 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sym   = 8'($urandom);
            @(posedge clk); #1;
            chk("bp.hold_ov", out_valid, 1);
            chk("bp.hold_rdy", in_ready, 0);
            chk("bp.hold_s0", s0, exp_s0);
            chk("bp.hold_s1", s1, exp_s1);
        end
        in_valid = 1'b0;
        handshake("bp.hs");

        // rst mid-codeword with bubbles.
        fill(1);
        send_cw(40, 1'b1, N);
        chk("rst_mid.cnt40", sym_cnt, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("rst_mid");
        fill(1);
        send_cw(N, 1'b1, N);
        check_result("after_rst", 1'b0);
        handshake("after_rst.hs");

        // clear mid-codeword, with a concurrent beat that must be dropped.
        fill(1);
        send_cw(40, 1'b1, N);
        in_valid = 1'b1;
        in_sym   = 8'hAA;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check_idle("clr_mid");
        fill(1);
        send_cw(N, 1'b1, N);
        check_result("after_clr", 1'b0);

        // clear discards a pending result.
        out_ready = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_idle("clr_done");

        for (int r = 0; r < 3; r++) begin
            fill(1);
            out_ready = 1'b1;
            send_cw(N, 1'b1, N);
            check_result("rand", 1'b0);
            @(posedge clk); #1;
            check_idle("rand.hs");
        end

`ifdef SYND_LAST_CHECK_EN
        fill(1);
        send_cw(N, 1'b0, N - 1);
        check_result("last79", 1'b1);
        @(posedge clk); #1;
        chk("last79.fe_clr", frame_err, 0);
        fill(1);
        send_cw(N, 1'b0, N);
        check_result("last80", 1'b0);
        @(posedge clk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_accum.md
Name: rs_syndrome_accum

Overview:
- Serial syndrome generator for the Unity ECC decoder over GF(2^8), primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (reduction byte 8'h5F).
- Accepts one received codeword symbol per cycle over a valid/ready handshake.
- Accumulates S0 and S1; presents them as one result beat to the downstream log-table stage, which converts S0 and S1 to exponents for error-location computation.

Parameters:
- N_SYM, 80, symbols per codeword; legal range 2..255.
- CNT_W, 8, symbol-counter width; must satisfy 2^CNT_W > N_SYM.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort of the current codeword
- in_valid  input  1  in_sym valid
- in_ready  output  1  block can accept a symbol
- in_sym  input  8  received symbol; first symbol of a codeword is index N_SYM-1, last is index 0
- out_valid  output  1  s0/s1 valid
- out_ready  input  1  downstream accepts result
- s0  output  8  S0 = XOR over i of c_i
- s1  output  8  S1 = XOR over i of c_i·α^i
- no_err  output  1  high when s0==0 and s1==0; qualified by out_valid
- sym_cnt  output  CNT_W  symbols accepted in current codeword (debug)

Behaviour:
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst=1 at edge):
  - state=ACCUM; acc0, acc1, sym_cnt = 0.
  - Outputs after reset: in_ready=1, out_valid=0, s0=0, s1=0, no_err=1, sym_cnt=0.
  - rst overrides clear and any handshake; reset mid-codeword discards partial sums.
- Accept: in_valid && in_ready at an edge.
  - acc0 <= acc0 ^ in_sym.
  - acc1 <= mulα(acc1) ^ in_sym (Horner form).
  - sym_cnt <= sym_cnt+1.
- mulα(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h5F : 8'h00). Pure XOR logic, no table lookup.
- Codeword completion:
  - When the accepted symbol brings sym_cnt to N_SYM, the next state is DONE.
  - s0/s1 then include that final symbol.
  - Latency: out_valid rises the cycle after the last symbol is accepted.
- DONE:
  - s0=acc0 and s1=acc1, held stable while out_valid && !out_ready.
  - in_valid is ignored; no symbols are accepted.
- Result handshake: on out_valid && out_ready, state <= ACCUM; acc0, acc1, sym_cnt <= 0 at the same edge.
  - Throughput: one codeword per N_SYM+1 cycles with no backpressure.
- s0/s1 in ACCUM show the running accumulators. They are not a result while out_valid=0.
- clear=1 in either state:
  - state <= ACCUM; accumulators and counter <= 0.
  - An input beat presented in the same cycle is dropped.
  - Any pending result is discarded.
- in_valid low mid-codeword inserts bubbles; sums and counter hold.
- sym_cnt never exceeds N_SYM. It wraps to 0 only via result handshake, clear or rst.
- no_err is combinational from s0/s1 registers.

Optional Feature:
- Macro: SYND_LAST_CHECK_EN.
- Defined:
  - Adds input in_last (1 bit, qualified by in_valid) and output frame_err (1 bit).
  - Completion condition remains sym_cnt reaching N_SYM.
  - frame_err is registered and set when:
    - in_last=1 is accepted with sym_cnt+1 != N_SYM, or
    - the N_SYM-th symbol is accepted with in_last=0.
  - frame_err is sticky until the result handshake, clear or rst; it is presented alongside out_valid.
  - On an early in_last, the block does not terminate the codeword. It keeps counting.
- Undefined: no in_last/frame_err ports and no check logic.

Test Plan:
- All-zero codeword, 80 symbols 8'h00, out_ready=1 → out_valid 1 cycle after the 80th accept; s0=8'h00, s1=8'h00, no_err=1; in_ready low for exactly 1 cycle.
- Single error 8'h01 at index 8 (9th-from-last symbol), rest 0 → s0=8'h01, s1=8'h5F, no_err=0.
- Single error 8'h03 at index 0 (last symbol), rest 0 → s0=8'h03, s1=8'h03. Then a second codeword with error 8'h01 at index 1 → s0=8'h01, s1=8'h02, confirming accumulators cleared at the handshake.
- Backpressure:
  - out_ready=0 for 10 cycles after completion → s0/s1/out_valid stable, in_ready=0, in_valid pulses ignored.
  - out_ready=1 → ACCUM next cycle, sym_cnt=0.
- Mid-codeword events:
  - Random in_valid bubbles plus rst asserted after 40 symbols → out_valid=0, sym_cnt=0, s0=s1=0; the following full codeword yields correct syndromes.
  - clear after 40 symbols → same result.
- SYND_LAST_CHECK_EN:
  - in_last on symbol 79 → frame_err=1 with out_valid.
  - in_last on symbol 80 → frame_err=0.
